// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with prescaler, one-shot and
// auto-reload modes.
//
// A start value is captured on load and counted down once per prescaled
// tick while running. Reaching zero raises a one-cycle terminal-count pulse
// and either reloads (periodic mode) or parks the timer in DONE (one-shot).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   load         in   capture reload_val into count and reload register
//   reload_val   in   [WIDTH]       value captured on load
//   start        in   begin / resume counting
//   stop         in   pause counting
//   auto_reload  in   1 = periodic, 0 = one-shot (sampled live)
//   prescale     in   [PRESCALE_W]  one tick every prescale+1 clocks (live)
//   q            out  [WIDTH]       current count
//   busy         out  state is RUN
//   done         out  state is DONE
//   tc           out  registered one-cycle terminal-count pulse
module down_timer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      reload_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic                  done,
  output logic                  tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PC_ONE  = PRESCALE_W'(1);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      reload_q, reload_d;
  logic [PRESCALE_W-1:0] pc_q, pc_d;
  logic                  tc_q, tc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      pc_q     <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      pc_q     <= pc_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    pc_d     = pc_q;
    tc_d     = 1'b0;

    if (load) begin
      // load overrides any start/stop in the same cycle
      cnt_d    = reload_val;
      reload_d = reload_val;
      pc_d     = '0;
      state_d  = IDLE;
    end else if (stop && (state_q == RUN)) begin
      // pause: count is held so a later start resumes from it
      state_d = IDLE;
      pc_d    = '0;
    end else if (start && (state_q == IDLE)) begin
      if (cnt_q != '0) begin
        state_d = RUN;
        pc_d    = '0;
      end else begin
        // nothing to count: expire immediately
        state_d = DONE;
        tc_d    = 1'b1;
      end
    end else if (start && (state_q == DONE)) begin
      if (reload_q != '0) begin
        cnt_d   = reload_q;
        state_d = RUN;
        pc_d    = '0;
      end else begin
        tc_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      // >= rather than == so lowering prescale mid-run cannot strand pc
      if (pc_q >= prescale) begin
        pc_d = '0;
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          tc_d = 1'b1;
          // a zero reload value cannot sustain a period: fall back to one-shot
          if (auto_reload && (reload_q != '0)) begin
            cnt_d = reload_q;
          end else begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end else begin
        pc_d = pc_q + PC_ONE;
      end
    end
  end

  assign q    = cnt_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign tc   = tc_q;

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] reload_val;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic [7:0] prescale;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       tc;

  int checks;
  int failures;

  down_timer #(.WIDTH(8), .PRESCALE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .reload_val (reload_val),
    .start      (start),
    .stop       (stop),
    .auto_reload(auto_reload),
    .prescale   (prescale),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .tc         (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge and settle; inputs set afterwards apply to the next edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({q, busy, done, tc} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state q=%0d busy=%0b done=%0b tc=%0b required q=0 busy=0 done=0 tc=0",
               q, busy, done, tc);
    end
    reset = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_q  [3] = '{8'd2, 8'd1, 8'd0};
    logic       exp_b  [3] = '{1'b1, 1'b1, 1'b0};
    logic       exp_t  [3] = '{1'b0, 1'b0, 1'b1};
    load = 1'b1; reload_val = 8'd3; prescale = 8'd0; auto_reload = 1'b0;
    step();
    load = 1'b0;
    checks++;
    if ({q, busy, done, tc} !== {8'd3, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL oneshot_load q=%0d busy=%0b done=%0b tc=%0b required q=3 busy=0 done=0 tc=0",
               q, busy, done, tc);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({q, busy, done, tc} !== {8'd3, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL oneshot_start q=%0d busy=%0b done=%0b tc=%0b required q=3 busy=1 done=0 tc=0",
               q, busy, done, tc);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({q, busy, done, tc} !== {exp_q[k], exp_b[k], exp_t[k], exp_t[k]}) begin
        failures++;
        $display("FAIL oneshot_edge%0d q=%0d busy=%0b done=%0b tc=%0b required q=%0d busy=%0b done=%0b tc=%0b",
                 k + 1, q, busy, done, tc, exp_q[k], exp_b[k], exp_t[k], exp_t[k]);
      end
    end
    step();
    checks++;
    if ({q, busy, done, tc} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL oneshot_after q=%0d busy=%0b done=%0b tc=%0b required q=0 busy=0 done=1 tc=0",
               q, busy, done, tc);
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] eq;
    logic       et;
    load = 1'b1; reload_val = 8'd2; prescale = 8'd0; auto_reload = 1'b1;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      eq = (k % 2 == 1) ? 8'd1 : 8'd2;
      et = (k % 2 == 0);
      checks++;
      if ({q, busy, done, tc} !== {eq, 1'b1, 1'b0, et}) begin
        failures++;
        $display("FAIL auto_edge%0d q=%0d busy=%0b done=%0b tc=%0b required q=%0d busy=1 done=0 tc=%0b",
                 k, q, busy, done, tc, eq, et);
      end
    end
    // leaving periodic mode mid-run: next expiry is one-shot
    auto_reload = 1'b0;
    step();
    step();
    checks++;
    if ({q, busy, done, tc} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL auto_to_oneshot q=%0d busy=%0b done=%0b tc=%0b required q=0 busy=0 done=1 tc=1",
               q, busy, done, tc);
    end
  endtask

  task automatic test_prescale_stop();
    logic [7:0] eq;
    logic       et;
    load = 1'b1; reload_val = 8'd4; prescale = 8'd2; auto_reload = 1'b0;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      eq = (k == 3) ? 8'd3 : 8'd4;
      checks++;
      if ({q, busy, tc} !== {eq, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL presc_edge%0d q=%0d busy=%0b tc=%0b required q=%0d busy=1 tc=0",
                 k, q, busy, tc, eq);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    step();
    checks++;
    if ({q, busy, done, tc} !== {8'd3, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL presc_stopped q=%0d busy=%0b done=%0b tc=%0b required q=3 busy=0 done=0 tc=0",
               q, busy, done, tc);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      eq = 8'd3 - 8'(k / 3);
      et = (k == 9);
      checks++;
      if ({q, busy, done, tc} !== {eq, ~et, et, et}) begin
        failures++;
        $display("FAIL presc_resume%0d q=%0d busy=%0b done=%0b tc=%0b required q=%0d busy=%0b done=%0b tc=%0b",
                 k, q, busy, done, tc, eq, ~et, et, et);
      end
    end
  endtask

  task automatic test_prescale_lowered();
    logic [7:0] exp_q [3] = '{8'd2, 8'd2, 8'd1};
    load = 1'b1; reload_val = 8'd3; prescale = 8'd5; auto_reload = 1'b0;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    // prescale counter is now 3, above the new prescale of 1
    prescale = 8'd1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({q, busy} !== {exp_q[k], 1'b1}) begin
        failures++;
        $display("FAIL presc_lower%0d q=%0d busy=%0b required q=%0d busy=1",
                 k, q, busy, exp_q[k]);
      end
    end
    prescale = 8'd0;
  endtask

  task automatic test_simultaneous();
    load = 1'b1; reload_val = 8'd5; prescale = 8'd0; auto_reload = 1'b0;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    load = 1'b1; start = 1'b1; reload_val = 8'd7;
    step();
    load = 1'b0; start = 1'b0; reload_val = 8'd99;
    checks++;
    if ({q, busy, done} !== {8'd7, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL load_with_start q=%0d busy=%0b done=%0b required q=7 busy=0 done=0",
               q, busy, done);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    checks++;
    if ({q, busy, done} !== {8'd6, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL stop_with_start q=%0d busy=%0b done=%0b required q=6 busy=0 done=0",
               q, busy, done);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    checks++;
    if ({q, busy, done, tc} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL sim_expire q=%0d busy=%0b done=%0b tc=%0b required q=0 busy=0 done=1 tc=1",
               q, busy, done, tc);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({q, busy, done, tc} !== {8'd7, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL restart_from_done q=%0d busy=%0b done=%0b tc=%0b required q=7 busy=1 done=0 tc=0",
               q, busy, done, tc);
    end
    step();
    checks++;
    if ({q, busy} !== {8'd6, 1'b1}) begin
      failures++;
      $display("FAIL restart_count q=%0d busy=%0b required q=6 busy=1", q, busy);
    end
  endtask

  task automatic test_zero();
    load = 1'b1; reload_val = 8'd0;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({q, busy, done, tc} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL zero_start q=%0d busy=%0b done=%0b tc=%0b required q=0 busy=0 done=1 tc=1",
               q, busy, done, tc);
    end
    step();
    checks++;
    if ({done, tc} !== {1'b1, 1'b0}) begin
      failures++;
      $display("FAIL zero_single_pulse done=%0b tc=%0b required done=1 tc=0", done, tc);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({q, busy, done, tc} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL zero_restart q=%0d busy=%0b done=%0b tc=%0b required q=0 busy=0 done=1 tc=1",
               q, busy, done, tc);
    end
    step();
    checks++;
    if (tc !== 1'b0) begin
      failures++;
      $display("FAIL zero_restart_pulse tc=%0b required tc=0", tc);
    end
  endtask

  task automatic test_reset_midrun();
    load = 1'b1; reload_val = 8'd200; prescale = 8'd0; auto_reload = 1'b0;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    checks++;
    if ({q, busy} !== {8'd190, 1'b1}) begin
      failures++;
      $display("FAIL midrun_count q=%0d busy=%0b required q=190 busy=1", q, busy);
    end
    reset = 1'b1; load = 1'b1; start = 1'b1; reload_val = 8'd55;
    step();
    reset = 1'b0; load = 1'b0; start = 1'b0;
    checks++;
    if ({q, busy, done, tc} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midrun_reset q=%0d busy=%0b done=%0b tc=%0b required q=0 busy=0 done=0 tc=0",
               q, busy, done, tc);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({q, busy, done, tc} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL post_reset_start q=%0d busy=%0b done=%0b tc=%0b required q=0 busy=0 done=1 tc=1",
               q, busy, done, tc);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; load = 1'b0; reload_val = '0; start = 1'b0; stop = 1'b0;
    auto_reload = 1'b0; prescale = '0;
    step();
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_prescale_stop();
    test_prescale_lowered();
    test_simultaneous();
    test_zero();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counting timer: the counterpart to the team's 8-bit loadable up-counter.
- Software or an FSM loads a start value and starts the timer. The timer decrements once per prescaled tick and flags terminal count.
- Supports one-shot and auto-reload modes. Used for delays, timeouts and periodic strobes.

Parameters:
- WIDTH, 8, width of the count value and reload register.
- PRESCALE_W, 8, width of the prescale input and the internal prescale counter.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture reload_val into both the count and the reload register.
- reload_val  input  WIDTH  value captured on load.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled live.
- prescale  input  PRESCALE_W  one tick every prescale+1 clocks; sampled live.
- q  output  WIDTH  current count.
- busy  output  1  high while in state RUN.
- done  output  1  high while in state DONE.
- tc  output  1  registered one-cycle terminal-count pulse.

Behaviour:
- One clock domain. The synchronous active-high reset is fixed.
- Reset has priority over everything. It sets q=0, reload_reg=0, prescale counter pc=0, state=IDLE, busy=0, done=0, tc=0.
- All outputs are registered or decoded from state only: busy = (state==RUN), done = (state==DONE).
- tc defaults to 0 every cycle and is only set on the events listed below.
- Per-cycle priority after reset: load > stop > start > tick.

States:
- IDLE: holds q. Entered from reset, load, or stop.
- RUN: counting.
- DONE: one-shot expired; q=0.

load (any state):
- q <= reload_val, reload_reg <= reload_val, pc <= 0, state <= IDLE.
- A start or stop in the same cycle is ignored.

stop:
- In RUN: state <= IDLE, pc <= 0, q held. A later start resumes from the held q.
- In other states: no effect.

start:
- In IDLE with q != 0: state <= RUN, pc <= 0.
- In IDLE with q == 0: state <= DONE, tc <= 1.
- In DONE with reload_reg != 0: q <= reload_reg, state <= RUN, pc <= 0.
- In DONE with reload_reg == 0: stay in DONE, tc <= 1.
- In RUN: ignored.

Prescaler (RUN only):
- If pc >= prescale: pc <= 0 and tick=1. Otherwise pc <= pc+1.
- The >= compare covers prescale being lowered mid-run.

Tick in RUN:
- If q > 1: q <= q-1.
- If q == 1: tc <= 1. Then:
  - if auto_reload: q <= reload_reg, stay in RUN;
  - else: q <= 0, state <= DONE.
- In auto mode with reload_reg == 0, behave as one-shot (q <= 0, state <= DONE).
- q == 0 is never held in RUN. No wrap-around below 0.

Timing:
- Start is sampled at edge 0. Tick k occurs at edge k*(prescale+1).
- For a start value N, tc is high in the cycle after edge N*(prescale+1).
- In auto mode the tc period is N*(prescale+1) clocks.

Other rules:
- tc, done and q update on the same edge.
- reload_val is read only on load.
- Reset asserted mid-RUN takes effect at the next edge, regardless of other inputs.

Test Plan:
1. Reset, then load=1 with reload_val=3, then start=1 with prescale=0 and auto_reload=0 -> q goes 3,2,1,0 on consecutive edges; busy=1 for 3 cycles; tc pulses once as q becomes 0; done=1 thereafter.
2. Load 2, auto_reload=1, prescale=0, start -> q sequence 2,1,2,1,2,…; tc pulses every 2 clocks; busy stays 1; done never asserts.
3. Load 4, prescale=2, start -> q decrements every 3 clocks; tc occurs 12 clocks after start; stop asserted after the first decrement freezes q=3 and busy=0; start resumes and q reaches 0 nine clocks later.
4. Simultaneous events: load=1 with start=1 in RUN -> IDLE with q=reload_val, not running. stop=1 with start=1 in RUN -> IDLE. Start in DONE -> q reloads from reload_reg and the timer runs again.
5. Zero cases: load 0 then start -> DONE with a single tc pulse and q=0. Start again in DONE -> another tc pulse, still in DONE.
6. Reset mid-run (load 200, start, assert reset after 10 clocks) -> next edge gives q=0, IDLE, busy=done=tc=0. A subsequent start without load goes to DONE with tc (q=0).
